lc3_probe_tracer: RTL

- Parametrised successor to the flat TA probe bundle for the LC3 pipeline.
- Takes NUM_CH probed stage signals with golden reference values, flags per-channel mismatches, and records snapshots into a circular trace buffer.
- Freezes the buffer a fixed number of samples after a trigger (mismatch or PC match); the bench then drains it oldest-first through a request/valid handshake.
- Sits beside the DUT in the wrapper; observes only, never drives the pipeline.

---
 rtl/lc3_probe_tracer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lc3_probe_tracer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lc3_probe_tracer : per-channel mismatch detector with triggered circular trace
// Revision: 1.0
// ---------------------------------------------------------------------------
module lc3_probe_tracer #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 16,
  parameter int DEPTH     = 32,
  parameter int POST_TRIG = 8,
  localparam int ENTRY_W  = NUM_CH*CH_W + NUM_CH + 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_CH*CH_W-1:0] probe_in,
  input  logic [NUM_CH*CH_W-1:0] ref_in,
  input  logic [NUM_CH-1:0]      cmp_mask,
  input  logic                   sample_en,
  input  logic                   arm,
  input  logic                   trig_pc_en,
  input  logic [15:0]            trig_pc,
  input  logic [15:0]            pc_in,
  input  logic                   rd_req,
  output logic [ENTRY_W-1:0]     rd_data,
  output logic                   rd_valid,
  output logic [1:0]             state,
  output logic [15:0]            mismatch_cnt,
  output logic [AW:0]            entries
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [AW-1:0] c_POST  = AW'(POST_TRIG);
  localparam logic [AW-1:0] c_ONE_A = AW'(1);
  localparam logic [AW:0]   c_ONE_S = (AW+1)'(1);
  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_stamp;
  logic [15:0]          r_mcnt;
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr, r_post;
  logic [AW:0]          r_stored, r_entries;
  logic [ENTRY_W-1:0]   r_rd_data;
  logic                 r_rd_valid;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];

  logic [NUM_CH-1:0]    w_mism;
  logic                 w_any_mism, w_trig, w_wr_en, w_enter_done;
  logic [AW-1:0]        w_wr_ptr_nxt;
  logic [AW:0]          w_stored_nxt;
  logic [ENTRY_W-1:0]   w_entry;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_mism
    assign w_mism[k] = sample_en & cmp_mask[k] &
                       (probe_in[k*CH_W +: CH_W] != ref_in[k*CH_W +: CH_W]);
  end

  assign w_any_mism   = |w_mism;
  assign w_trig       = w_any_mism | (trig_pc_en & sample_en & (pc_in == trig_pc));
  assign w_wr_en      = sample_en & ((r_state == S_ARMED) | (r_state == S_POST));
  assign w_wr_ptr_nxt = r_wr_ptr + c_ONE_A;
  assign w_stored_nxt = (r_stored == c_DEPTH) ? r_stored : r_stored + c_ONE_S;
  assign w_entry      = {r_stamp, w_mism, probe_in};
  assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (arm) w_state_nxt = S_ARMED;
      S_ARMED: if (w_wr_en && w_trig) w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
      S_POST:  if (w_wr_en && (r_post == c_ONE_A)) w_state_nxt = S_DONE;
      S_DONE:  if (rd_req && (r_entries == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Trace storage carries no reset; validity is tracked by r_stored/r_entries.
  always_ff @(posedge clock) begin
    if (!reset && w_wr_en) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stamp    <= '0;
      r_mcnt     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post     <= '0;
      r_stored   <= '0;
      r_entries  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_stamp    <= r_stamp + 16'd1;
      r_rd_valid <= 1'b0;
      if (w_any_mism && (r_mcnt != 16'hFFFF)) r_mcnt <= r_mcnt + 16'd1;
      if ((r_state == S_IDLE) && arm) begin
        r_wr_ptr <= '0;
        r_stored <= '0;
      end
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_stored <= w_stored_nxt;
      end
      if ((r_state == S_ARMED) && w_wr_en && w_trig) r_post <= c_POST;
      if ((r_state == S_POST) && w_wr_en)            r_post <= r_post - c_ONE_A;
      // Oldest surviving entry sits 'stored' slots behind the final write pointer.
      if (w_enter_done) begin
        r_rd_ptr  <= w_wr_ptr_nxt - w_stored_nxt[AW-1:0];
        r_entries <= w_stored_nxt;
      end
      if ((r_state == S_DONE) && rd_req && (r_entries != '0)) begin
        r_rd_data  <= r_mem[r_rd_ptr];
        r_rd_valid <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + c_ONE_A;
        r_entries  <= r_entries - c_ONE_S;
      end
    end
  end

  assign state        = r_state;
  assign mismatch_cnt = r_mcnt;
  assign entries      = r_entries;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;

endmodule
`default_nettype wire
